// File: rtl/inter_tx_scheduler_pkg.sv
// Shared interboard definitions: message layout, message-type codes and the
// transmit sequencer states.
package inter_tx_scheduler_pkg;

  localparam int MSG_TYPE_W = 3;
  localparam int MSG_NUM_W  = 5;
  localparam int MSG_W      = MSG_TYPE_W + MSG_NUM_W;

  typedef enum logic [MSG_TYPE_W-1:0] {
    MSG_NONE  = 3'd0,
    MSG_START = 3'd1,
    MSG_MOVE  = 3'd2,
    MSG_LINE  = 3'd3,
    MSG_WIN   = 3'd4,
    MSG_ACK   = 3'd5,
    MSG_RESET = 3'd6,
    MSG_RSVD  = 3'd7
  } msg_type_e;

  typedef struct packed {
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [MSG_NUM_W-1:0]  number;
  } msg_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOW  = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } seq_state_e;

  function automatic msg_t pack_msg(input logic [MSG_TYPE_W-1:0] msg_type,
                                    input logic [MSG_NUM_W-1:0]  number);
    msg_t m;
    m.msg_type = msg_type;
    m.number   = number;
    return m;
  endfunction

endpackage

// File: rtl/inter_tx_scheduler_msg_fifo.sv
// Outgoing message FIFO: power-of-two depth, head visible combinationally,
// synchronous flush clears pointers and occupancy.
module msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inter_tx_scheduler.sv
// Inter-board transmit scheduler: round-robin arbitration of two requesters
// into a message FIFO, drained one message per link handshake.
import inter_tx_scheduler_pkg::*;

module inter_tx_scheduler #(
  parameter int DEPTH       = 4,
  parameter int LOW_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     interboard_rst,
  input  logic                     req0_valid,
  input  logic [2:0]               req0_msg_type,
  input  logic [4:0]               req0_number,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [2:0]               req1_msg_type,
  input  logic [4:0]               req1_number,
  output logic                     req1_ready,
  input  logic                     inter_ready,
  output logic                     transmit,
  output logic                     ctrl_en,
  output logic [2:0]               ctrl_msg_type,
  output logic [4:0]               ctrl_number,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);
  localparam int TW = $clog2(LOW_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(LOW_TIMEOUT - 1);

  logic       flush, fifo_full, fifo_empty, push, tx;
  logic       grant0, grant1;
  logic       last1_q, last1_d;
  msg_t       push_msg, head_msg, ctrl_q, ctrl_d;
  seq_state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;

  assign flush = rst || interboard_rst;

  // Round-robin: last1_q set means req1 won the most recent accepted push.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last1_q);
    grant1     = req1_valid && (!req0_valid || !last1_q);
    req0_ready = grant0 && !fifo_full && !flush;
    req1_ready = grant1 && !fifo_full && !flush;
    push       = req0_ready || req1_ready;
    push_msg   = req1_ready ? pack_msg(req1_msg_type, req1_number)
                            : pack_msg(req0_msg_type, req0_number);
    last1_d    = push ? req1_ready : last1_q;
  end

  msg_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .flush     (flush),
    .push      (push),
    .push_data (push_msg),
    .pop       (tx),
    .head      (head_msg),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      last1_q <= 1'b1;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      last1_q <= last1_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (tx) begin
          state_d = ST_WAIT_LOW;
          tmr_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (!inter_ready)          state_d = ST_WAIT_HIGH;
        else if (tmr_q == TMR_LAST) state_d = ST_IDLE;
        else                        tmr_d   = tmr_q + 1'b1;
      end
      ST_WAIT_HIGH: begin
        if (inter_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Link command fields hold their last transmitted value between pulses.
  always_comb begin
    tx            = (state_q == ST_IDLE) && !fifo_empty && inter_ready && !flush;
    ctrl_d        = tx ? head_msg : ctrl_q;
    transmit      = tx;
    ctrl_en       = tx;
    ctrl_msg_type = flush ? '0 : ctrl_d.msg_type;
    ctrl_number   = flush ? '0 : ctrl_d.number;
    busy          = !fifo_empty || (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_inter_tx_scheduler.sv
// Bench for inter_tx_scheduler: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_inter_tx_scheduler;
  localparam int DEPTH       = 4;
  localparam int LOW_TIMEOUT = 8;
  localparam int CW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, interboard_rst;
  logic          req0_valid, req1_valid, inter_ready;
  logic [2:0]    req0_msg_type, req1_msg_type;
  logic [4:0]    req0_number, req1_number;
  logic          req0_ready, req1_ready, transmit, ctrl_en, busy;
  logic [2:0]    ctrl_msg_type;
  logic [4:0]    ctrl_number;
  logic [CW-1:0] fifo_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: message queue, who won last, and link handshake progress.
  logic [7:0] mq[$];
  bit         m_last1;
  bit         m_flight;
  bit         m_seen_low;
  int         m_wait;
  logic [7:0] m_ctrl;

  always #10 clk = ~clk;

  inter_tx_scheduler #(
    .DEPTH       (DEPTH),
    .LOW_TIMEOUT (LOW_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .req0_valid     (req0_valid),
    .req0_msg_type  (req0_msg_type),
    .req0_number    (req0_number),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_msg_type  (req1_msg_type),
    .req1_number    (req1_number),
    .req1_ready     (req1_ready),
    .inter_ready    (inter_ready),
    .transmit       (transmit),
    .ctrl_en        (ctrl_en),
    .ctrl_msg_type  (ctrl_msg_type),
    .ctrl_number    (ctrl_number),
    .fifo_count     (fifo_count),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_last1    = 1'b1;
    m_flight   = 1'b0;
    m_seen_low = 1'b0;
    m_wait     = 0;
    m_ctrl     = 8'h00;
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic cycle();
    bit         flush, full, e_r0, e_r1, e_tx;
    logic [7:0] e_ctrl;
    @(negedge clk);
    flush  = rst || interboard_rst;
    full   = (mq.size() == DEPTH);
    e_r0   = !flush && !full && req0_valid && (!req1_valid || m_last1);
    e_r1   = !flush && !full && req1_valid && (!req0_valid || !m_last1);
    e_tx   = !flush && !m_flight && (mq.size() != 0) && inter_ready;
    e_ctrl = flush ? 8'h00 : (e_tx ? mq[0] : m_ctrl);
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    check("transmit", transmit, e_tx);
    check("ctrl_en", ctrl_en, e_tx);
    check("ctrl_msg_type", ctrl_msg_type, e_ctrl[7:5]);
    check("ctrl_number", ctrl_number, e_ctrl[4:0]);
    check("fifo_count", fifo_count, mq.size());
    check("busy", busy, (mq.size() != 0) || m_flight);
    @(posedge clk);
    if (flush) begin
      model_reset();
    end else begin
      if (e_tx) m_ctrl = mq.pop_front();
      if (e_r0) mq.push_back({req0_msg_type, req0_number});
      else if (e_r1) mq.push_back({req1_msg_type, req1_number});
      if (e_r0 || e_r1) m_last1 = e_r1;
      if (e_tx) begin
        m_flight   = 1'b1;
        m_seen_low = 1'b0;
        m_wait     = 0;
      end else if (m_flight) begin
        if (m_seen_low) begin
          if (inter_ready) m_flight = 1'b0;
        end else if (!inter_ready) begin
          m_seen_low = 1'b1;
        end else begin
          m_wait++;
          if (m_wait == LOW_TIMEOUT) m_flight = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; interboard_rst = 1'b0;
    req0_valid = 1'b0; req0_msg_type = '0; req0_number = '0;
    req1_valid = 1'b0; req1_msg_type = '0; req1_number = '0;
    inter_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    settle();
    check("rst_req0_ready", req0_ready, 1'b0);
    rst = 1'b0;
    settle();
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_transmit", transmit, 1'b0);
    check("rst_ctrl_type", ctrl_msg_type, 3'd0);
    check("rst_ctrl_num", ctrl_number, 5'd0);

    // Single message straight through, then the WAIT_LOW timeout path.
    req0_valid = 1'b1; req0_msg_type = 3'd2; req0_number = 5'd17; inter_ready = 1'b1;
    settle();
    check("first_req0_ready", req0_ready, 1'b1);
    cycle();
    req0_valid = 1'b0;
    settle();
    check("first_tx", transmit, 1'b1);
    check("first_type", ctrl_msg_type, 3'd2);
    check("first_num", ctrl_number, 5'd17);
    cycle();
    req1_valid = 1'b1; req1_msg_type = 3'd5; req1_number = 5'd9;
    settle();
    check("wl_busy", busy, 1'b1);
    check("wl_no_tx", transmit, 1'b0);
    check("wl_hold_type", ctrl_msg_type, 3'd2);
    cycle();
    req1_valid = 1'b0;
    for (int i = 2; i <= LOW_TIMEOUT; i++) begin
      settle();
      check("wl_hold_tx", transmit, 1'b0);
      cycle();
    end
    settle();
    check("timeout_tx", transmit, 1'b1);
    check("timeout_type", ctrl_msg_type, 3'd5);
    check("timeout_num", ctrl_number, 5'd9);
    cycle();
    inter_ready = 1'b0;
    cycle(); cycle();
    inter_ready = 1'b1;
    cycle();

    // Both requesters valid, link busy: grants alternate until full.
    inter_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_msg_type = 3'd1; req0_number = 5'(i);
      req1_valid = 1'b1; req1_msg_type = 3'd3; req1_number = 5'(16 + i);
      settle();
      check("rr_req0_ready", req0_ready, (i % 2) == 0);
      check("rr_req1_ready", req1_ready, (i % 2) == 1);
      cycle();
    end
    settle();
    check("full_count", fifo_count, 4);
    check("full_req0_ready", req0_ready, 1'b0);
    check("full_req1_ready", req1_ready, 1'b0);

    // Full FIFO with a pop: req1 waits one cycle, then gets in.
    req0_valid = 1'b0; req1_number = 5'd20; inter_ready = 1'b1;
    settle();
    check("fullpop_tx", transmit, 1'b1);
    check("fullpop_num", ctrl_number, 5'd0);
    check("fullpop_req1_ready", req1_ready, 1'b0);
    check("fullpop_count", fifo_count, 4);
    cycle();
    settle();
    check("after_pop_count", fifo_count, 3);
    check("after_pop_req1_ready", req1_ready, 1'b1);
    cycle();
    req1_valid = 1'b0; inter_ready = 1'b0;
    settle();
    check("refill_count", fifo_count, 4);

    // Full handshakes: FIFO order preserved, spacing at least 3 cycles.
    for (int k = 0; k < 2; k++) begin
      inter_ready = 1'b0;
      cycle(); cycle();
      inter_ready = 1'b1;
      settle();
      check("wh_no_tx", transmit, 1'b0);
      cycle();
      settle();
      check("order_tx", transmit, 1'b1);
      check("order_num", ctrl_number, (k == 0) ? 5'd17 : 5'd2);
      cycle();
    end

    // Flush from the link while waiting with three messages queued.
    inter_ready = 1'b0; req0_valid = 1'b1; req0_msg_type = 3'd4; req0_number = 5'd30;
    cycle();
    req0_valid = 1'b0;
    cycle();
    settle();
    check("pre_flush_count", fifo_count, 3);
    check("pre_flush_busy", busy, 1'b1);
    interboard_rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    settle();
    check("flush_req0_ready", req0_ready, 1'b0);
    check("flush_req1_ready", req1_ready, 1'b0);
    cycle();
    interboard_rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; inter_ready = 1'b1;
    settle();
    check("post_flush_count", fifo_count, 0);
    check("post_flush_busy", busy, 1'b0);
    for (int i = 0; i < 10; i++) begin
      inter_ready = i[0];
      settle();
      check("post_flush_no_tx", transmit, 1'b0);
      cycle();
    end

    // Random traffic with occasional resets of either kind.
    for (int i = 0; i < 3000; i++) begin
      req0_valid     = 1'($urandom_range(0, 1));
      req0_msg_type  = 3'($urandom_range(0, 7));
      req0_number    = 5'($urandom_range(0, 31));
      req1_valid     = 1'($urandom_range(0, 1));
      req1_msg_type  = 3'($urandom_range(0, 7));
      req1_number    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) < 3) inter_ready = ~inter_ready;
      interboard_rst = ($urandom_range(0, 79) == 0);
      rst            = ($urandom_range(0, 149) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inter_tx_scheduler.md
INTER_TX_SCHEDULER -- requirements
Module: inter_tx_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, outgoing message FIFO depth (power of two, 2..8).
REQ-002 SHALL have parameter LOW_TIMEOUT, default 8, the number of cycles to wait for inter_ready to fall after a transmit.
REQ-003 SHALL have port clk  input  1  the single clock (50 MHz domain); all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port interboard_rst  input  1  synchronous active-high flush from the link; same effect as rst.
REQ-006 SHALL have ports req0_valid input 1, req0_msg_type input 3, req0_number input 5, req0_ready output 1: the game-FSM message requester.
REQ-007 SHALL have ports req1_valid input 1, req1_msg_type input 3, req1_number input 5, req1_ready output 1: the secondary requester (line/win reporter).
REQ-008 SHALL have port inter_ready  input  1  link idle indication from the interboard communication block.
REQ-009 SHALL have ports transmit output 1, ctrl_en output 1, ctrl_msg_type output 3, ctrl_number output 5: link command.
REQ-010 SHALL have ports fifo_count output $clog2(DEPTH)+1 and busy output 1 (FIFO non-empty or state not IDLE).

Function
REQ-011 A requester SHALL be accepted on a cycle where its valid and ready are both 1; each message is 8 bits {msg_type, number}.
REQ-012 At most one message SHALL be pushed per cycle; reqN_ready SHALL be 1 only for the granted requester, and only when FIFO not full.
REQ-013 Grant SHALL be round-robin: with both valid, grant the requester not granted most recently; with one valid, grant it; the pointer updates only on an accepted push.
REQ-014 reqN_ready SHALL be combinational from valids, pointer and fifo_count (not from the pop of the same cycle).
REQ-015 FIFO SHALL be first-in first-out; push and pop in the same cycle SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-016 Sequencer states SHALL be IDLE, WAIT_LOW, WAIT_HIGH.
REQ-017 IDLE: when FIFO non-empty and inter_ready=1, assert transmit=1 and ctrl_en=1 for exactly one cycle with head msg_type/number, pop the head, go to WAIT_LOW.
REQ-018 WAIT_LOW: on inter_ready=0 go to WAIT_HIGH; if inter_ready stays 1 for LOW_TIMEOUT cycles, return to IDLE.
REQ-019 WAIT_HIGH: on inter_ready=1 return to IDLE; no timeout.
REQ-020 Outside the transmit cycle, transmit and ctrl_en SHALL be 0, and ctrl_msg_type and ctrl_number SHALL hold their last driven value.
REQ-021 Minimum spacing between transmit pulses SHALL be 3 cycles (IDLE -> WAIT_LOW -> WAIT_HIGH -> IDLE).
REQ-022 Empty FIFO SHALL never issue transmit; full FIFO SHALL deassert both readys.

Reset
REQ-023 On rst or interboard_rst: FIFO emptied, fifo_count=0, state IDLE, round-robin pointer favours req0, transmit=0, ctrl_en=0, ctrl_msg_type=0, ctrl_number=0, busy=0, both readys 0 in that cycle.
REQ-024 A reset mid-handshake SHALL abandon the in-flight message; no transmit is issued in the cycle reset is asserted.

Structure
REQ-025 Message-type encodings (3-bit) and the 8-bit message width SHALL live in the shared interboard package used by game and communication blocks.
REQ-026 The FIFO SHALL be one sub-module, msg_fifo (parameterised width/depth, push/pop/count); arbiter and sequencer stay in the top.

Verification
REQ-027 Reset then req0 pushes {type=3'd2, num=5'd17} with inter_ready=1 -> transmit one cycle later with ctrl_msg_type=2, ctrl_number=17, then state WAIT_LOW.
REQ-028 req0 and req1 valid continuously, inter_ready=0 -> grants alternate 0,1,0,1; after 4 pushes fifo_count=4 and both readys 0.
REQ-029 FIFO holds A,B; inter_ready toggles 1->0 (2 cycles)->1 after each transmit -> transmits A then B in order, ≥3 cycles apart.
REQ-030 inter_ready held 1 after transmit -> return to IDLE after exactly 8 cycles in WAIT_LOW, next message then sent.
REQ-031 interboard_rst pulse with fifo_count=3 in WAIT_HIGH -> next cycle fifo_count=0, busy=0, no transmit afterwards.
REQ-032 Full FIFO plus pop in IDLE with req1 valid -> req1_ready=0 that cycle, accepted next cycle, fifo_count 4->3->4.
